// File: rtl/i281_pkg.sv
// ---------------------------------------------------------------------------
// i281_pkg
// Shared constants for the i281 front end and control FSM:
//   - opcode nibble values (IR[15:12])
//   - one-hot bit indices of the 23 decoded instructions (the FSM's numbering)
//   - sub-code values (IR[9:8]) for the INPUT, shift and branch families
// ---------------------------------------------------------------------------
package i281_pkg;

    localparam int OPC_W    = 27;   // {RX, RY, onehot}
    localparam int ONEHOT_W = 23;

    // Opcode nibbles
    localparam logic [3:0] OP_NOOP   = 4'h0;
    localparam logic [3:0] OP_INPUT  = 4'h1;
    localparam logic [3:0] OP_MOVE   = 4'h2;
    localparam logic [3:0] OP_LOADI  = 4'h3;
    localparam logic [3:0] OP_ADD    = 4'h4;
    localparam logic [3:0] OP_ADDI   = 4'h5;
    localparam logic [3:0] OP_SUB    = 4'h6;
    localparam logic [3:0] OP_SUBI   = 4'h7;
    localparam logic [3:0] OP_LOAD   = 4'h8;
    localparam logic [3:0] OP_LOADF  = 4'h9;
    localparam logic [3:0] OP_STORE  = 4'hA;
    localparam logic [3:0] OP_STOREF = 4'hB;
    localparam logic [3:0] OP_SHIFT  = 4'hC;
    localparam logic [3:0] OP_CMP    = 4'hD;
    localparam logic [3:0] OP_JUMP   = 4'hE;
    localparam logic [3:0] OP_BRANCH = 4'hF;

    // One-hot bit indices
    localparam int OH_NOOP    = 0;
    localparam int OH_INPUTC  = 1;
    localparam int OH_INPUTCF = 2;
    localparam int OH_INPUTD  = 3;
    localparam int OH_INPUTDF = 4;
    localparam int OH_MOVE    = 5;
    localparam int OH_LOADI   = 6;
    localparam int OH_ADD     = 7;
    localparam int OH_ADDI    = 8;
    localparam int OH_SUB     = 9;
    localparam int OH_SUBI    = 10;
    localparam int OH_LOAD    = 11;
    localparam int OH_LOADF   = 12;
    localparam int OH_STORE   = 13;
    localparam int OH_STOREF  = 14;
    localparam int OH_SHIFTL  = 15;
    localparam int OH_SHIFTR  = 16;
    localparam int OH_CMP     = 17;
    localparam int OH_JUMP    = 18;
    localparam int OH_BRE     = 19;
    localparam int OH_BRNE    = 20;
    localparam int OH_BRG     = 21;
    localparam int OH_BRGE    = 22;

    // Family sub-codes (IR[9:8])
    localparam logic [1:0] SUB_INPUTC  = 2'b00;
    localparam logic [1:0] SUB_INPUTCF = 2'b01;
    localparam logic [1:0] SUB_INPUTD  = 2'b10;
    localparam logic [1:0] SUB_INPUTDF = 2'b11;
    localparam logic [1:0] SUB_SHIFTL  = 2'b00;
    localparam logic [1:0] SUB_SHIFTR  = 2'b01;
    localparam logic [1:0] SUB_BRE     = 2'b00;
    localparam logic [1:0] SUB_BRNE    = 2'b01;
    localparam logic [1:0] SUB_BRG     = 2'b10;
    localparam logic [1:0] SUB_BRGE    = 2'b11;

    // Single-bit one-hot vector for a bit index
    function automatic logic [ONEHOT_W-1:0] onehot_bit(input int idx);
        logic [ONEHOT_W-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/i281_opcode_decoder.sv
// ---------------------------------------------------------------------------
// i281_opcode_decoder
// Purely combinational decode of IR[15:8] into the control FSM's opcode word.
// Ports:
//   ir_hi_i    in  8   IR[15:8] = {opcode, RX, RY}
//   opcode_o   out 27  {RX, RY, onehot[22:0]}
//   illegal_o  out 1   IR holds an undefined sub-code (shift family, RY=1x)
// ---------------------------------------------------------------------------
module i281_opcode_decoder
    import i281_pkg::*;
(
    input  logic [7:0]       ir_hi_i,
    output logic [OPC_W-1:0] opcode_o,
    output logic             illegal_o
);

    logic [3:0]          op;
    logic [1:0]          ry;
    logic [ONEHOT_W-1:0] onehot;

    assign op = ir_hi_i[7:4];
    assign ry = ir_hi_i[1:0];

    always_comb begin
        onehot    = onehot_bit(OH_NOOP);
        illegal_o = 1'b0;
        unique case (op)
            OP_NOOP:   onehot = onehot_bit(OH_NOOP);
            OP_INPUT: begin
                unique case (ry)
                    SUB_INPUTC:  onehot = onehot_bit(OH_INPUTC);
                    SUB_INPUTCF: onehot = onehot_bit(OH_INPUTCF);
                    SUB_INPUTD:  onehot = onehot_bit(OH_INPUTD);
                    SUB_INPUTDF: onehot = onehot_bit(OH_INPUTDF);
                endcase
            end
            OP_MOVE:   onehot = onehot_bit(OH_MOVE);
            OP_LOADI:  onehot = onehot_bit(OH_LOADI);
            OP_ADD:    onehot = onehot_bit(OH_ADD);
            OP_ADDI:   onehot = onehot_bit(OH_ADDI);
            OP_SUB:    onehot = onehot_bit(OH_SUB);
            OP_SUBI:   onehot = onehot_bit(OH_SUBI);
            OP_LOAD:   onehot = onehot_bit(OH_LOAD);
            OP_LOADF:  onehot = onehot_bit(OH_LOADF);
            OP_STORE:  onehot = onehot_bit(OH_STORE);
            OP_STOREF: onehot = onehot_bit(OH_STOREF);
            OP_SHIFT: begin
                if (ry == SUB_SHIFTL)      onehot = onehot_bit(OH_SHIFTL);
                else if (ry == SUB_SHIFTR) onehot = onehot_bit(OH_SHIFTR);
                else begin
                    // Undefined shift: execute as NOOP so the FSM still sees one hot bit
                    onehot    = onehot_bit(OH_NOOP);
                    illegal_o = 1'b1;
                end
            end
            OP_CMP:    onehot = onehot_bit(OH_CMP);
            OP_JUMP:   onehot = onehot_bit(OH_JUMP);
            OP_BRANCH: begin
                unique case (ry)
                    SUB_BRE:  onehot = onehot_bit(OH_BRE);
                    SUB_BRNE: onehot = onehot_bit(OH_BRNE);
                    SUB_BRG:  onehot = onehot_bit(OH_BRG);
                    SUB_BRGE: onehot = onehot_bit(OH_BRGE);
                endcase
            end
        endcase
    end

    // RX/RY pass through untouched, even for the sub-coded families
    assign opcode_o = {ir_hi_i[3:0], onehot};

endmodule

// File: rtl/instr_fetch_decode.sv
// ---------------------------------------------------------------------------
// instr_fetch_decode
// i281 fetch/decode front end: PC, IR, combinational decode, branch target,
// sticky illegal flag and saturating retired-instruction counter.
// Ports:
//   clock, reset_n   clock (rising) / async active-low reset
//   imem_addr        out PC_W  instruction address (= pc)
//   imem_rdata       in  16    combinational instruction read data
//   ir_load          in  1     IR <= imem_rdata
//   pc_inc           in  1     PC <= PC + 1
//   pc_branch        in  1     PC <= PC + sext(imm)  (wins over pc_inc)
//   pc, ir           out       current PC / instruction register
//   opcode_out       out 27    {RX, RY, onehot[22:0]} for the control FSM
//   imm              out 8     IR[7:0]
//   illegal          out 1     sticky undefined-sub-code flag
//   retired          out CNT_W saturating count of ir_load events
// ---------------------------------------------------------------------------
module instr_fetch_decode
    import i281_pkg::*;
#(
    parameter int PC_W  = 6,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    output logic [PC_W-1:0]  imem_addr,
    input  logic [15:0]      imem_rdata,
    input  logic             ir_load,
    input  logic             pc_inc,
    input  logic             pc_branch,
    output logic [PC_W-1:0]  pc,
    output logic [15:0]      ir,
    output logic [OPC_W-1:0] opcode_out,
    output logic [7:0]       imm,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    logic [PC_W-1:0]  pc_q, pc_d;
    logic [15:0]      ir_q, ir_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             dec_illegal;
    logic [31:0]      br_off32;
    logic [PC_W-1:0]  br_off;

    i281_opcode_decoder u_dec (
        .ir_hi_i   (ir_q[15:8]),
        .opcode_o  (opcode_out),
        .illegal_o (dec_illegal)
    );

    // Sign-extend the 8-bit offset, then keep PC_W bits: arithmetic wraps mod 2^PC_W
    assign br_off32 = 32'($signed(ir_q[7:0]));
    assign br_off   = br_off32[PC_W-1:0];

    always_comb begin
        pc_d      = pc_q;
        ir_d      = ir_q;
        illegal_d = illegal_q | dec_illegal;
        retired_d = retired_q;
        if (pc_branch)   pc_d = pc_q + br_off;
        else if (pc_inc) pc_d = pc_q + 1'b1;
        if (ir_load) begin
            ir_d = imem_rdata;
            if (retired_q != '1) retired_d = retired_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q      <= '0;
            ir_q      <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            illegal_q <= illegal_d;
            retired_q <= retired_d;
        end
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign imm       = ir_q[7:0];
    assign illegal   = illegal_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
module tb_instr_fetch_decode;

    logic        clock;
    logic        reset_n;
    logic [5:0]  imem_addr;
    logic [15:0] imem_rdata;
    logic        ir_load, pc_inc, pc_branch;
    logic [5:0]  pc;
    logic [15:0] ir;
    logic [26:0] opcode_out;
    logic [7:0]  imm;
    logic        illegal;
    logic [15:0] retired;

    logic [15:0] imem [64];
    assign imem_rdata = imem[imem_addr];

    int total_cnt = 0;
    int pass_cnt  = 0;

    // Reference model state
    int          m_pc;
    logic [15:0] m_ir;
    logic        m_ill;
    int          m_ret;

    instr_fetch_decode #(.PC_W(6), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .ir_load(ir_load), .pc_inc(pc_inc), .pc_branch(pc_branch), .pc(pc), .ir(ir),
        .opcode_out(opcode_out), .imm(imm), .illegal(illegal), .retired(retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction-set level view of an encoding
    function automatic bit is_illegal(input logic [15:0] w);
        return (w[15:12] == 4'hC) && w[9];
    endfunction

    function automatic int exp_idx(input logic [15:0] w);
        int op, ry;
        op = int'(w[15:12]);
        ry = int'(w[9:8]);
        if (op == 0)  return 0;
        if (op == 1)  return 1 + ry;
        if (op <= 11) return op + 3;
        if (op == 12) return (ry < 2) ? 15 + ry : 0;
        if (op == 13) return 17;
        if (op == 14) return 18;
        return 19 + ry;
    endfunction

    function automatic logic [26:0] exp_op(input logic [15:0] w);
        logic [22:0] oh;
        oh = '0;
        oh[exp_idx(w)] = 1'b1;
        return {w[11:8], oh};
    endfunction

    task automatic model_reset();
        m_pc = 0; m_ir = 16'h0; m_ill = 1'b0; m_ret = 0;
    endtask

    task automatic apply_reset();
        ir_load = 0; pc_inc = 0; pc_branch = 0;
        @(negedge clock); reset_n = 1'b0;
        @(negedge clock); reset_n = 1'b1;
        model_reset();
    endtask

    // One clock edge with the given controls; model advances alongside
    task automatic step(input bit ld, input bit inc, input bit br);
        int off, n_pc;
        ir_load = ld; pc_inc = inc; pc_branch = br;
        off  = m_ir[7] ? int'(m_ir[7:0]) - 256 : int'(m_ir[7:0]);
        n_pc = m_pc;
        if (br)       n_pc = (((m_pc + off) % 64) + 64) % 64;
        else if (inc) n_pc = (m_pc + 1) % 64;
        @(posedge clock);
        #1;
        m_ill = m_ill | is_illegal(m_ir);
        if (ld) begin
            m_ir = imem[m_pc];
            if (m_ret < 65535) m_ret++;
        end
        m_pc = n_pc;
        ir_load = 0; pc_inc = 0; pc_branch = 0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        total_cnt++; if (pc !== 6'd0) $display("FAIL reset_pc got=%0d exp=0", pc); else pass_cnt++;
        total_cnt++; if (ir !== 16'h0) $display("FAIL reset_ir got=%h exp=0000", ir); else pass_cnt++;
        total_cnt++; if (opcode_out !== 27'h1) $display("FAIL reset_opcode got=%h exp=0000001", opcode_out); else pass_cnt++;
        total_cnt++; if (illegal !== 1'b0) $display("FAIL reset_illegal got=%b exp=0", illegal); else pass_cnt++;
        total_cnt++; if (retired !== 16'd0) $display("FAIL reset_retired got=%0d exp=0", retired); else pass_cnt++;
    endtask

    task automatic test_first_fetch();
        apply_reset();
        imem[0] = 16'h4600;
        step(1, 1, 0);
        total_cnt++; if (pc !== 6'd1) $display("FAIL fetch_pc got=%0d exp=1", pc); else pass_cnt++;
        total_cnt++; if (opcode_out !== {2'b01, 2'b10, 23'h80})
            $display("FAIL fetch_add_opcode got=%h exp=%h", opcode_out, {2'b01, 2'b10, 23'h80}); else pass_cnt++;
        total_cnt++; if (retired !== 16'd1) $display("FAIL fetch_retired got=%0d exp=1", retired); else pass_cnt++;
    endtask

    task automatic test_decode_sweep();
        logic [15:0] w;
        int nsub;
        apply_reset();
        for (int op = 0; op < 16; op++) begin
            nsub = (op == 1 || op == 15) ? 4 : (op == 12) ? 2 : 1;
            for (int s = 0; s < nsub; s++) begin
                w = 16'($urandom);
                w[15:12] = 4'(op);
                if (nsub > 1) w[9:8] = 2'(s);
                imem[m_pc] = w;
                step(1, 1, 0);
                total_cnt++; if (opcode_out !== exp_op(w))
                    $display("FAIL sweep_opcode w=%h got=%h exp=%h", w, opcode_out, exp_op(w)); else pass_cnt++;
                total_cnt++; if ($countones(opcode_out[22:0]) != 1)
                    $display("FAIL sweep_onehot w=%h got=%h exp=one bit", w, opcode_out[22:0]); else pass_cnt++;
            end
        end
        total_cnt++; if (illegal !== 1'b0) $display("FAIL sweep_illegal got=%b exp=0", illegal); else pass_cnt++;
    endtask

    task automatic test_branch();
        apply_reset();
        imem[4] = 16'hF3FD;
        for (int i = 0; i < 4; i++) step(0, 1, 0);
        step(1, 1, 0);
        total_cnt++; if (pc !== 6'd5) $display("FAIL br_fetch_pc got=%0d exp=5", pc); else pass_cnt++;
        total_cnt++; if (opcode_out !== {4'h3, 23'h400000})
            $display("FAIL br_brge_opcode got=%h exp=%h", opcode_out, {4'h3, 23'h400000}); else pass_cnt++;
        total_cnt++; if (imm !== 8'hFD) $display("FAIL br_imm got=%h exp=fd", imm); else pass_cnt++;
        step(0, 0, 1);
        total_cnt++; if (pc !== 6'd2) $display("FAIL br_target got=%0d exp=2", pc); else pass_cnt++;
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        step(0, 1, 1);
        total_cnt++; if (pc !== 6'd2) $display("FAIL br_over_inc got=%0d exp=2", pc); else pass_cnt++;
    endtask

    task automatic test_wrap();
        apply_reset();
        for (int i = 0; i < 63; i++) step(0, 1, 0);
        total_cnt++; if (pc !== 6'd63) $display("FAIL wrap_pc63 got=%0d exp=63", pc); else pass_cnt++;
        step(0, 1, 0);
        total_cnt++; if (pc !== 6'd0) $display("FAIL wrap_inc got=%0d exp=0", pc); else pass_cnt++;
        imem[0] = 16'h00F0;
        step(1, 1, 0);
        step(0, 0, 1);
        total_cnt++; if (pc !== 6'd49) $display("FAIL wrap_neg_branch got=%0d exp=49", pc); else pass_cnt++;
    endtask

    task automatic test_illegal();
        apply_reset();
        imem[0] = 16'hC300;
        imem[1] = 16'h4600;
        step(1, 1, 0);
        total_cnt++; if (opcode_out !== {4'h3, 23'h1})
            $display("FAIL ill_noop got=%h exp=%h", opcode_out, {4'h3, 23'h1}); else pass_cnt++;
        step(0, 0, 0);
        total_cnt++; if (illegal !== 1'b1) $display("FAIL ill_set got=%b exp=1", illegal); else pass_cnt++;
        step(1, 1, 0);
        step(0, 0, 0);
        total_cnt++; if (illegal !== 1'b1) $display("FAIL ill_sticky got=%b exp=1", illegal); else pass_cnt++;
        apply_reset();
        #1;
        total_cnt++; if (illegal !== 1'b0) $display("FAIL ill_cleared got=%b exp=0", illegal); else pass_cnt++;
    endtask

    task automatic test_async_reset();
        apply_reset();
        imem[0] = 16'hC300;
        step(1, 1, 0);
        step(1, 1, 0);
        step(0, 1, 0);
        #2;
        reset_n = 1'b0;
        #1;
        total_cnt++; if (pc !== 6'd0) $display("FAIL areset_pc got=%0d exp=0", pc); else pass_cnt++;
        total_cnt++; if (opcode_out !== 27'h1) $display("FAIL areset_opcode got=%h exp=0000001", opcode_out); else pass_cnt++;
        total_cnt++; if (illegal !== 1'b0) $display("FAIL areset_illegal got=%b exp=0", illegal); else pass_cnt++;
        total_cnt++; if (retired !== 16'd0) $display("FAIL areset_retired got=%0d exp=0", retired); else pass_cnt++;
        @(negedge clock); reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_random();
        bit ld, inc, br;
        apply_reset();
        for (int i = 0; i < 64; i++) imem[i] = 16'($urandom);
        for (int n = 0; n < 300; n++) begin
            ld  = ($urandom_range(0, 3) != 0);
            inc = ($urandom_range(0, 3) != 0);
            br  = ($urandom_range(0, 5) == 0);
            step(ld, inc, br);
            total_cnt++;
            if (pc !== 6'(m_pc) || ir !== m_ir || opcode_out !== exp_op(m_ir) ||
                imm !== m_ir[7:0] || illegal !== m_ill || retired !== 16'(m_ret))
                $display("FAIL rand_step%0d got pc=%0d ir=%h op=%h il=%b ret=%0d exp pc=%0d ir=%h op=%h il=%b ret=%0d",
                         n, pc, ir, opcode_out, illegal, retired, m_pc, m_ir, exp_op(m_ir), m_ill, m_ret);
            else pass_cnt++;
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int i = 0; i < 65535; i++) step(1, 0, 0);
        total_cnt++; if (retired !== 16'hFFFF) $display("FAIL sat_reach got=%h exp=ffff", retired); else pass_cnt++;
        step(1, 0, 0);
        total_cnt++; if (retired !== 16'hFFFF) $display("FAIL sat_hold got=%h exp=ffff", retired); else pass_cnt++;
    endtask

    initial begin
        reset_n = 1'b1;
        ir_load = 0; pc_inc = 0; pc_branch = 0;
        for (int i = 0; i < 64; i++) imem[i] = 16'h0;
        model_reset();
        test_reset();
        test_first_fetch();
        test_decode_sweep();
        test_branch();
        test_wrap();
        test_illegal();
        test_async_reset();
        test_random();
        test_saturate();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
